// File: rtl/mux_pkg.sv
// Shared constants, FSM encoding and slice helper for the N-to-1 word multiplexers.
package mux_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    // Fill bit for the word emitted on an out-of-range select (all-zero word).
    localparam logic SELERR_DATA = 1'b0;

    // Encoding is {main valid, skid valid}.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } state_e;

    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/muxn_comb.sv
// Purely combinational N-to-1 word selector with an out-of-range flag.
module muxn_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W_DEFAULT,
    parameter int unsigned N     = 2,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   dout_o,
    output logic               sel_err_o
);

    always_comb begin
        dout_o    = {WIDTH{SELERR_DATA}};
        sel_err_o = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SEL_W'(i)) begin
                dout_o    = din_i[slice_lsb(i, WIDTH) +: WIDTH];
                sel_err_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N-to-1 word mux with valid/ready handshake and a one-entry skid buffer.
module muxn_pipe
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W_DEFAULT,
    parameter int unsigned N     = 2,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] Din,
    input  logic [SEL_W-1:0]   Sel,
    input  logic               InValid,
    output logic               InReady,
    output logic [WIDTH-1:0]   Dout,
    output logic               SelErr,
    output logic               OutValid,
    input  logic               OutReady
);

    state_e             state_q;
    logic [WIDTH-1:0]   main_data_q, skid_data_q;
    logic               main_err_q, skid_err_q;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_err;
    logic               in_xfer, out_xfer;

    muxn_comb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_sel (
        .din_i     (Din),
        .sel_i     (Sel),
        .dout_o    (sel_data),
        .sel_err_o (sel_err)
    );

    // InReady depends only on state and Reset, never on OutReady.
    assign InReady  = (state_q != StFull) & ~Reset;
    assign OutValid = (state_q != StEmpty);
    assign Dout     = main_data_q;
    assign SelErr   = main_err_q;
    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_data_q <= sel_data;
                        main_err_q  <= sel_err;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_data_q <= sel_data;
                        main_err_q  <= sel_err;
                    end else if (in_xfer) begin
                        skid_data_q <= sel_data;
                        skid_err_q  <= sel_err;
                        state_q     <= StFull;
                    end else if (out_xfer) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_data_q <= skid_data_q;
                        main_err_q  <= skid_err_q;
                        skid_data_q <= '0;
                        skid_err_q  <= 1'b0;
                        state_q     <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed and randomised-stall checks of muxn_pipe across several N/WIDTH configurations.
module tb_muxn_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=2, WIDTH=32
    logic [63:0] din2;  logic sel2;        logic iv2, ir2, ov2, or2, err2; logic [31:0] dout2;
    // N=4, WIDTH=32
    logic [127:0] din4; logic [1:0] sel4;  logic iv4, ir4, ov4, or4, err4; logic [31:0] dout4;
    // N=3, WIDTH=32
    logic [95:0] din3;  logic [1:0] sel3;  logic iv3, ir3, ov3, or3, err3; logic [31:0] dout3;
    // N=5, WIDTH=8
    logic [39:0] din5;  logic [2:0] sel5;  logic iv5, ir5, ov5, or5, err5; logic [7:0] dout5;

    muxn_pipe #(.WIDTH(32), .N(2)) u2 (
        .Clk(clk), .Reset(rst), .Din(din2), .Sel(sel2), .InValid(iv2), .InReady(ir2),
        .Dout(dout2), .SelErr(err2), .OutValid(ov2), .OutReady(or2));
    muxn_pipe #(.WIDTH(32), .N(4)) u4 (
        .Clk(clk), .Reset(rst), .Din(din4), .Sel(sel4), .InValid(iv4), .InReady(ir4),
        .Dout(dout4), .SelErr(err4), .OutValid(ov4), .OutReady(or4));
    muxn_pipe #(.WIDTH(32), .N(3)) u3 (
        .Clk(clk), .Reset(rst), .Din(din3), .Sel(sel3), .InValid(iv3), .InReady(ir3),
        .Dout(dout3), .SelErr(err3), .OutValid(ov3), .OutReady(or3));
    muxn_pipe #(.WIDTH(8), .N(5)) u5 (
        .Clk(clk), .Reset(rst), .Din(din5), .Sel(sel5), .InValid(iv5), .InReady(ir5),
        .Dout(dout5), .SelErr(err5), .OutValid(ov5), .OutReady(or5));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        sel;
        logic        iv;
        logic        ordy;
        logic [31:0] dout;
        logic        ov;
        logic        err;
        logic        ir;
    } vec_t;

    function automatic vec_t mkv(input logic [31:0] d0, input logic [31:0] d1, input logic sel,
                                 input logic iv, input logic ordy, input logic [31:0] dout,
                                 input logic ov, input logic err, input logic ir);
        vec_t v;
        v.d0 = d0; v.d1 = d1; v.sel = sel; v.iv = iv; v.ordy = ordy;
        v.dout = dout; v.ov = ov; v.err = err; v.ir = ir;
        return v;
    endfunction

    vec_t vt[$];
    logic [8:0] sb[$];
    logic [8:0] exp_w;

    initial begin
        rst = 1'b1;
        din2 = '0; sel2 = '0; iv2 = 1'b0; or2 = 1'b0;
        din4 = '0; sel4 = '0; iv4 = 1'b0; or4 = 1'b0;
        din3 = '0; sel3 = '0; iv3 = 1'b0; or3 = 1'b0;
        din5 = '0; sel5 = '0; iv5 = 1'b0; or5 = 1'b0;

        // Reset state, held across an active edge.
        #7;
        chk("rst_inready", 32'(ir2), 32'd0);
        chk("rst_outvalid", 32'(ov2), 32'd0);
        chk("rst_dout", dout2, 32'd0);
        chk("rst_selerr", 32'(err2), 32'd0);
        #5 rst = 1'b0;
        #1;
        chk("post_rst_inready", 32'(ir2), 32'd1);

        // Pass-through, then an 8-word back-to-back stream, then drain.
        vt.push_back(mkv(32'h0, 32'h1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1));
        vt.push_back(mkv(32'h0, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 8; k++) begin
            vt.push_back(mkv(32'h100 + 32'(k), 32'h200 + 32'(k), k[0], 1'b1, 1'b1,
                             k[0] ? 32'h200 + 32'(k) : 32'h100 + 32'(k), 1'b1, 1'b0, 1'b1));
        end
        vt.push_back(mkv(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < vt.size(); i++) begin
            din2 = {vt[i].d1, vt[i].d0};
            sel2 = vt[i].sel; iv2 = vt[i].iv; or2 = vt[i].ordy;
            tick();
            chk($sformatf("vec%0d_outvalid", i), 32'(ov2), 32'(vt[i].ov));
            chk($sformatf("vec%0d_inready", i), 32'(ir2), 32'(vt[i].ir));
            if (vt[i].ov) begin
                chk($sformatf("vec%0d_dout", i), dout2, vt[i].dout);
                chk($sformatf("vec%0d_selerr", i), 32'(err2), 32'(vt[i].err));
            end
        end

        // Back-pressure on N=4: third word must wait, order preserved.
        din4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
        tick();
        chk("bp_first_dout", dout4, 32'hA0);
        chk("bp_first_inready", 32'(ir4), 32'd1);
        sel4 = 2'd1;
        tick();
        chk("bp_full_inready", 32'(ir4), 32'd0);
        chk("bp_full_dout", dout4, 32'hA0);
        sel4 = 2'd2;
        tick();
        chk("bp_stall_inready", 32'(ir4), 32'd0);
        chk("bp_stall_dout", dout4, 32'hA0);
        chk("bp_stall_outvalid", 32'(ov4), 32'd1);
        or4 = 1'b1;
        tick();
        chk("bp_drain1_dout", dout4, 32'hA1);
        chk("bp_drain1_inready", 32'(ir4), 32'd1);
        tick();
        chk("bp_drain2_dout", dout4, 32'hA2);
        iv4 = 1'b0;
        tick();
        chk("bp_empty_outvalid", 32'(ov4), 32'd0);

        // Out-of-range select on N=3.
        din3 = {32'h33, 32'h22, 32'h11};
        or3 = 1'b1; iv3 = 1'b1; sel3 = 2'd3;
        tick();
        chk("oor_dout", dout3, 32'h0);
        chk("oor_selerr", 32'(err3), 32'd1);
        chk("oor_outvalid", 32'(ov3), 32'd1);
        sel3 = 2'd2;
        tick();
        chk("oor_next_dout", dout3, 32'h33);
        chk("oor_next_selerr", 32'(err3), 32'd0);
        iv3 = 1'b0;
        tick();

        // Reset mid-operation from FULL.
        din2 = {32'hBEEF, 32'hDEAD};
        or2 = 1'b0; iv2 = 1'b1; sel2 = 1'b0;
        tick();
        sel2 = 1'b1;
        tick();
        chk("midrst_full_inready", 32'(ir2), 32'd0);
        iv2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_outvalid", 32'(ov2), 32'd0);
        chk("midrst_dout", dout2, 32'h0);
        chk("midrst_inready", 32'(ir2), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_release_inready", 32'(ir2), 32'd1);
        or2 = 1'b1;
        tick();
        tick();
        chk("midrst_no_stale", 32'(ov2), 32'd0);

        // Random stall stress on N=5, WIDTH=8 with a FIFO scoreboard.
        begin
            int sent = 0;
            int cyc = 0;
            logic prev_stall = 1'b0;
            logic [7:0] prev_dout = '0;
            logic prev_err = 1'b0;
            while (cyc < 20000 && (sent < 1000 || sb.size() > 0)) begin
                if (prev_stall) begin
                    chk("stress_hold_valid", 32'(ov5), 32'd1);
                    chk("stress_hold_dout", 32'(dout5), 32'(prev_dout));
                    chk("stress_hold_err", 32'(err5), 32'(prev_err));
                end
                or5 = ($urandom_range(0, 9) < 6);
                if (ov5 && or5) begin
                    if (sb.size() == 0) begin
                        chk("stress_unexpected_word", 32'(ov5), 32'd0);
                    end else begin
                        exp_w = sb.pop_front();
                        chk("stress_dout", 32'(dout5), 32'(exp_w[7:0]));
                        chk("stress_err", 32'(err5), 32'(exp_w[8]));
                    end
                end
                prev_stall = ov5 & ~or5;
                prev_dout = dout5;
                prev_err = err5;
                iv5 = (sent < 1000) && ($urandom_range(0, 9) < 7);
                din5 = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
                sel5 = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                    : 3'($urandom_range(0, 4));
                if (iv5 && ir5) begin
                    if (sel5 < 3'd5) sb.push_back({1'b0, din5[32'(sel5) * 8 +: 8]});
                    else             sb.push_back({1'b1, 8'h00});
                    sent++;
                end
                tick();
                cyc++;
            end
            iv5 = 1'b0;
            chk("stress_all_sent", 32'(sent), 32'd1000);
            chk("stress_scoreboard_empty", 32'(sb.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
